fifo_1clk_std: RTL and testbench

- Single-clock block-RAM FIFO with the same write/read/status interface the team uses for its Xilinx async FIFO wrapper (fifo_hs): wr_en/full on the write side, rd_en/empty/dout on the read side.
- Standard (non-FWFT) read mode with 1-cycle read latency, plus overflow/underflow, programmable thresholds, data counts and reset-busy flags.
- Sits between a producer and a valid/ready adapter that derives rd_en and vld from empty.

---
 rtl/fifo_1clk_std.sv | 134 +++++++++++++
 tb/tb_fifo_1clk_std.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_1clk_std.sv
// Single-clock block-RAM FIFO in standard read mode (1-cycle read latency).
// Flags are registered from next-state occupancy. Data counts saturate.
module fifo_1clk_std #(
   parameter int unsigned           FIFO_WRITE_DEPTH    = 128,
   parameter int unsigned           DATA_WIDTH          = 32,
   parameter int unsigned           WR_DATA_COUNT_WIDTH = 7,
   parameter int unsigned           RD_DATA_COUNT_WIDTH = 7,
   parameter int unsigned           PROG_FULL_THRESH    = 10,
   parameter int unsigned           PROG_EMPTY_THRESH   = 10,
   parameter logic [DATA_WIDTH-1:0] DOUT_RESET_VALUE    = '0
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           wr_en,
   input  logic [DATA_WIDTH-1:0]          din,
   output logic                           full,
   output logic                           overflow,
   output logic                           wr_rst_busy,
   input  logic                           rd_en,
   output logic [DATA_WIDTH-1:0]          dout,
   output logic                           empty,
   output logic                           underflow,
   output logic                           rd_rst_busy,
   output logic                           prog_full,
   output logic                           prog_empty,
   output logic [WR_DATA_COUNT_WIDTH-1:0] wr_data_count,
   output logic [RD_DATA_COUNT_WIDTH-1:0] rd_data_count
);

   localparam int unsigned AW         = $clog2(FIFO_WRITE_DEPTH);
   localparam int unsigned WR_CNT_MAX = (32'd1 << WR_DATA_COUNT_WIDTH) - 32'd1;
   localparam int unsigned RD_CNT_MAX = (32'd1 << RD_DATA_COUNT_WIDTH) - 32'd1;
   localparam logic [2:0]  BUSY_EDGES = 3'd4;

   logic [DATA_WIDTH-1:0]          mem_q [FIFO_WRITE_DEPTH];
   logic [AW:0]                    wr_ptr_q, wr_ptr_d;
   logic [AW:0]                    rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0]          dout_q, dout_d;
   logic                           full_q, full_d;
   logic                           empty_q, empty_d;
   logic                           prog_full_q, prog_full_d;
   logic                           prog_empty_q, prog_empty_d;
   logic                           overflow_q, overflow_d;
   logic                           underflow_q, underflow_d;
   logic [WR_DATA_COUNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic [RD_DATA_COUNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
   logic [2:0]                     busy_cnt_q, busy_cnt_d;
   logic                           rst_busy_q, rst_busy_d;
   logic                           wr_accept, rd_accept;
   logic [AW:0]                    occ_d;
   logic [31:0]                    occ32;

   always_comb begin
      wr_accept = wr_en & ~full_q & ~rst_busy_q;
      rd_accept = rd_en & ~empty_q & ~rst_busy_q;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;
      if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         dout_d   = mem_q[rd_ptr_q[AW-1:0]];
      end

      occ_d        = wr_ptr_d - rd_ptr_d;
      occ32        = 32'(occ_d);
      full_d       = (occ32 == FIFO_WRITE_DEPTH);
      empty_d      = (occ32 == 32'd0);
      prog_full_d  = (occ32 >= PROG_FULL_THRESH);
      prog_empty_d = (occ32 <= PROG_EMPTY_THRESH);
      overflow_d   = wr_en & (full_q | rst_busy_q);
      underflow_d  = rd_en & (empty_q | rst_busy_q);

      wr_cnt_d = (occ32 > WR_CNT_MAX) ? WR_DATA_COUNT_WIDTH'(WR_CNT_MAX)
                                      : WR_DATA_COUNT_WIDTH'(occ32);
      rd_cnt_d = (occ32 > RD_CNT_MAX) ? RD_DATA_COUNT_WIDTH'(RD_CNT_MAX)
                                      : RD_DATA_COUNT_WIDTH'(occ32);

      // Busy holds through the first four edges after reset release.
      busy_cnt_d = busy_cnt_q;
      if (busy_cnt_q != BUSY_EDGES) busy_cnt_d = busy_cnt_q + 3'd1;
      rst_busy_d = (busy_cnt_d != BUSY_EDGES);
   end

   always_ff @(posedge clk) begin
      if (wr_accept) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         dout_q       <= DOUT_RESET_VALUE;
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
         prog_full_q  <= 1'b0;
         prog_empty_q <= 1'b1;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         busy_cnt_q   <= '0;
         rst_busy_q   <= 1'b1;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         dout_q       <= dout_d;
         full_q       <= full_d;
         empty_q      <= empty_d;
         prog_full_q  <= prog_full_d;
         prog_empty_q <= prog_empty_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         busy_cnt_q   <= busy_cnt_d;
         rst_busy_q   <= rst_busy_d;
      end
   end

   assign full          = full_q;
   assign empty         = empty_q;
   assign prog_full     = prog_full_q;
   assign prog_empty    = prog_empty_q;
   assign overflow      = overflow_q;
   assign underflow     = underflow_q;
   assign dout          = dout_q;
   assign wr_data_count = wr_cnt_q;
   assign rd_data_count = rd_cnt_q;
   assign wr_rst_busy   = rst_busy_q;
   assign rd_rst_busy   = rst_busy_q;

endmodule

// File: tb/tb_fifo_1clk_std.sv
// Self-checking bench for fifo_1clk_std: vector table, directed corner
// sequences, and random traffic checked against a queue-based reference.
module tb_fifo_1clk_std;

   localparam int unsigned DEPTH = 128;
   localparam int unsigned DW    = 32;
   localparam int unsigned CW    = 7;
   localparam int unsigned CMAX  = 127;

   logic          clk     = 1'b0;
   logic          reset_n = 1'b1;
   logic          wr_en   = 1'b0;
   logic          rd_en   = 1'b0;
   logic [DW-1:0] din     = '0;
   logic          full, overflow, wr_rst_busy, empty, underflow, rd_rst_busy;
   logic          prog_full, prog_empty;
   logic [DW-1:0] dout;
   logic [CW-1:0] wr_data_count, rd_data_count;

   fifo_1clk_std #(
      .FIFO_WRITE_DEPTH    (DEPTH),
      .DATA_WIDTH          (DW),
      .WR_DATA_COUNT_WIDTH (CW),
      .RD_DATA_COUNT_WIDTH (CW),
      .PROG_FULL_THRESH    (10),
      .PROG_EMPTY_THRESH   (10),
      .DOUT_RESET_VALUE    (32'h0)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .wr_en         (wr_en),
      .din           (din),
      .full          (full),
      .overflow      (overflow),
      .wr_rst_busy   (wr_rst_busy),
      .rd_en         (rd_en),
      .dout          (dout),
      .empty         (empty),
      .underflow     (underflow),
      .rd_rst_busy   (rd_rst_busy),
      .prog_full     (prog_full),
      .prog_empty    (prog_empty),
      .wr_data_count (wr_data_count),
      .rd_data_count (rd_data_count)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a plain queue plus a count of remaining busy edges.
   logic [DW-1:0] mq[$];
   int            m_busy = 4;
   logic [DW-1:0] m_dout = '0;
   logic          m_ovf  = 1'b0;
   logic          m_udf  = 1'b0;
   bit            m_bsy, m_wok, m_rok;
   int            m_n;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         m_busy = 4;
         m_dout = '0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         m_n   = mq.size();
         m_bsy = (m_busy > 0);
         m_wok = wr_en && (m_n < DEPTH) && !m_bsy;
         m_rok = rd_en && (m_n > 0) && !m_bsy;
         m_ovf = wr_en && ((m_n == DEPTH) || m_bsy);
         m_udf = rd_en && ((m_n == 0) || m_bsy);
         if (m_rok) m_dout = mq.pop_front();
         if (m_wok) mq.push_back(din);
         if (m_busy > 0) m_busy--;
      end
   end

   bit chk_on = 1'b0;
   int c_n;

   always @(negedge clk) begin
      if (chk_on) begin
         c_n = mq.size();
         cmp("m_full",       full,          c_n == DEPTH);
         cmp("m_empty",      empty,         c_n == 0);
         cmp("m_prog_full",  prog_full,     c_n >= 10);
         cmp("m_prog_empty", prog_empty,    c_n <= 10);
         cmp("m_overflow",   overflow,      m_ovf);
         cmp("m_underflow",  underflow,     m_udf);
         cmp("m_wr_busy",    wr_rst_busy,   m_busy > 0);
         cmp("m_rd_busy",    rd_rst_busy,   m_busy > 0);
         cmp("m_dout",       dout,          m_dout);
         cmp("m_wr_count",   wr_data_count, (c_n > CMAX) ? CMAX : c_n);
         cmp("m_rd_count",   rd_data_count, (c_n > CMAX) ? CMAX : c_n);
      end
   end

   typedef struct {
      logic          wr;
      logic          rd;
      logic [DW-1:0] wdata;
      logic          busy;
      logic          emp;
      logic          ovf;
      logic          udf;
      logic [DW-1:0] rdata;
      logic [CW-1:0] cnt;
   } vec_t;

   vec_t tbl [12];
   int   sent, rx;
   bit   pend;
   int   wp [4];
   int   rp [4];

   task automatic wait_busy_clear();
      for (int i = 0; i < 10; i++) begin
         if (!wr_rst_busy) break;
         tick();
      end
      cmp("busy_clear", wr_rst_busy, 1'b0);
   endtask

   task automatic reset_dut();
      reset_n = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      wait_busy_clear();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // Outputs observed in each row come from the inputs of the row before.
      //          wr    rd    wdata    busy  emp   ovf   udf   rdata    cnt
      tbl[0]  = '{1'b1, 1'b0, 32'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 7'd0};
      tbl[1]  = '{1'b0, 1'b1, 32'h00, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00, 7'd0};
      tbl[2]  = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00, 7'd0};
      tbl[3]  = '{1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 7'd0};
      tbl[4]  = '{1'b1, 1'b0, 32'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 7'd0};
      tbl[5]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 7'd1};
      tbl[6]  = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h22, 7'd0};
      tbl[7]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h22, 7'd0};
      tbl[8]  = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 1'b0, 32'h22, 7'd0};
      tbl[9]  = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h22, 7'd1};
      tbl[10] = '{1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h22, 7'd1};
      tbl[11] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h33, 7'd0};

      #1;
      reset_n = 1'b0;
      chk_on  = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      cmp("rst_wr_busy",    wr_rst_busy,   1'b1);
      cmp("rst_rd_busy",    rd_rst_busy,   1'b1);
      cmp("rst_empty",      empty,         1'b1);
      cmp("rst_full",       full,          1'b0);
      cmp("rst_prog_empty", prog_empty,    1'b1);
      cmp("rst_prog_full",  prog_full,     1'b0);
      cmp("rst_dout",       dout,          32'h0);
      cmp("rst_wr_count",   wr_data_count, 7'd0);
      cmp("rst_overflow",   overflow,      1'b0);
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         cmp($sformatf("tv%0d_wr_busy", i), wr_rst_busy,   tbl[i].busy);
         cmp($sformatf("tv%0d_rd_busy", i), rd_rst_busy,   tbl[i].busy);
         cmp($sformatf("tv%0d_empty", i),   empty,         tbl[i].emp);
         cmp($sformatf("tv%0d_ovf", i),     overflow,      tbl[i].ovf);
         cmp($sformatf("tv%0d_udf", i),     underflow,     tbl[i].udf);
         cmp($sformatf("tv%0d_dout", i),    dout,          tbl[i].rdata);
         cmp($sformatf("tv%0d_count", i),   rd_data_count, tbl[i].cnt);
         wr_en = tbl[i].wr;
         rd_en = tbl[i].rd;
         din   = tbl[i].wdata;
         tick();
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      tick();

      // Fill 0..127, then one rejected write.
      for (int k = 0; k < DEPTH; k++) begin
         wr_en = 1'b1;
         din   = DW'(k);
         tick();
         cmp("fill_count",      wr_data_count, (k + 1 > CMAX) ? CMAX : k + 1);
         cmp("fill_prog_full",  prog_full,     k + 1 >= 10);
         cmp("fill_prog_empty", prog_empty,    k + 1 <= 10);
         cmp("fill_full",       full,          k == DEPTH - 1);
      end
      din = 32'd999;
      tick();
      wr_en = 1'b0;
      cmp("ovf_flag",  overflow,      1'b1);
      cmp("ovf_full",  full,          1'b1);
      cmp("ovf_count", wr_data_count, 7'd127);
      tick();
      cmp("ovf_clear", overflow,      1'b0);
      cmp("ovf_rcnt",  rd_data_count, 7'd127);

      // Drain, then one rejected read.
      for (int k = 0; k < DEPTH; k++) begin
         rd_en = 1'b1;
         tick();
         cmp("drain_dout",  dout,  DW'(k));
         cmp("drain_empty", empty, k == DEPTH - 1);
      end
      tick();
      rd_en = 1'b0;
      cmp("udf_flag", underflow, 1'b1);
      cmp("udf_dout", dout,      32'd127);
      tick();
      cmp("udf_clear",     underflow, 1'b0);
      cmp("udf_dout_hold", dout,      32'd127);

      // Streaming with a receiver that reads whenever not empty.
      sent = 0;
      rx   = 0;
      for (int c = 0; c < 2200 && rx < 2000; c++) begin
         wr_en = (sent < 2000);
         din   = DW'(sent);
         rd_en = !empty;
         pend  = rd_en;
         tick();
         if (wr_en) sent++;
         if (pend) begin
            cmp("stream_dout", dout, DW'(rx));
            rx++;
         end
         cmp("stream_bound", wr_data_count <= 7'd2, 1'b1);
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
      cmp("stream_count", rx, 2000);
      tick();

      // Simultaneous write and read while full: only the read goes through.
      for (int k = 0; k < DEPTH; k++) begin
         wr_en = 1'b1;
         din   = 32'h500 + DW'(k);
         tick();
      end
      cmp("bfull_full", full, 1'b1);
      wr_en = 1'b1;
      rd_en = 1'b1;
      din   = 32'hDEAD;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      cmp("bfull_full_after", full,          1'b0);
      cmp("bfull_count",      wr_data_count, 7'd127);
      cmp("bfull_ovf",        overflow,      1'b1);
      cmp("bfull_dout",       dout,          32'h500);
      tick();
      cmp("bfull_full_stays", full,          1'b0);

      // Random traffic with varying write/read bias.
      wp = '{80, 20, 60, 50};
      rp = '{20, 80, 60, 50};
      for (int seg = 0; seg < 4; seg++) begin
         for (int c = 0; c < 600; c++) begin
            wr_en = ($urandom_range(0, 99) < wp[seg]);
            rd_en = ($urandom_range(0, 99) < rp[seg]);
            din   = $urandom();
            tick();
         end
      end
      wr_en = 1'b0;
      rd_en = 1'b0;

      // Reset with 50 words stored discards them.
      reset_dut();
      for (int k = 0; k < 50; k++) begin
         wr_en = 1'b1;
         din   = 32'h1000 + DW'(k);
         tick();
      end
      wr_en = 1'b0;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      cmp("mid_pre_dout", dout, 32'h1000);
      reset_n = 1'b0;
      #1;
      cmp("mid_empty",  empty,         1'b1);
      cmp("mid_wcount", wr_data_count, 7'd0);
      cmp("mid_rcount", rd_data_count, 7'd0);
      cmp("mid_dout",   dout,          32'h0);
      cmp("mid_full",   full,          1'b0);
      tick();
      tick();
      reset_n = 1'b1;
      wait_busy_clear();
      wr_en = 1'b1;
      din   = 32'hBEEF;
      tick();
      wr_en = 1'b0;
      cmp("mid_new_empty", empty, 1'b0);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      cmp("mid_new_dout", dout, 32'hBEEF);
      tick();
      cmp("mid_final_empty", empty, 1'b1);

      chk_on = 1'b0;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
